// File: rtl/lcd_seq_ctrl_if.sv
// Handshake bundle between the LCD sequencer and the LCD init/refresh engine.
// master = sequencer side, slave = engine/safe-logic side.
interface lcd_seq_ctrl_if;
    logic       upd_req;
    logic       lcd_finish;
    logic       lcd_enable;
    logic       mode;
    logic [1:0] lcd_cnt;
    logic       lcd_busy;
    logic       init_done;
    logic       lcd_err;

    modport master (
        input  upd_req,
        input  lcd_finish,
        output lcd_enable,
        output mode,
        output lcd_cnt,
        output lcd_busy,
        output init_done,
        output lcd_err
    );

    modport slave (
        output upd_req,
        output lcd_finish,
        input  lcd_enable,
        input  mode,
        input  lcd_cnt,
        input  lcd_busy,
        input  init_done,
        input  lcd_err
    );
endinterface

// File: rtl/lcd_seq_ctrl.sv
// Power-up/init/refresh sequencer for the safe's LCD engine.
// Optional WAIT-state timeout with sticky error: define LCD_TIMEOUT_EN.
module lcd_seq_ctrl #(
    parameter int CNT_W      = 8,
    parameter int PWRUP_MS   = 20,
    parameter int INIT_CNT   = 3,
    parameter int REFR_CNT   = 3,
    parameter int REFRESH_MS = 250,
    parameter int TIMEOUT_MS = 50
) (
    input  logic          clk_1ms,
    input  logic          reset,
    lcd_seq_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        PWRUP,
        INIT_REQ,
        INIT_WAIT,
        IDLE,
        REFR_REQ,
        REFR_WAIT
    } state_e;

    localparam logic [CNT_W-1:0] PWRUP_TERM = CNT_W'(PWRUP_MS - 1);
    localparam logic [CNT_W-1:0] REFR_TERM  = CNT_W'(REFRESH_MS - 1);
    localparam logic [1:0]       INIT_V     = 2'(INIT_CNT);
    localparam logic [1:0]       REFR_V     = 2'(REFR_CNT);

    if (PWRUP_MS < 1 || REFRESH_MS < 2 || TIMEOUT_MS < 1 ||
        PWRUP_MS >= (1 << CNT_W) || REFRESH_MS >= (1 << CNT_W) ||
        TIMEOUT_MS >= (1 << CNT_W)) begin : g_bad_cfg
        $error("lcd_seq_ctrl: ms parameter out of counter range");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             mode_q, mode_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

`ifdef LCD_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_TERM = CNT_W'(TIMEOUT_MS - 1);
    logic err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        // a request in any state is remembered; the IDLE launch may clear it
        pend_d  = pend_q | bus.upd_req;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
`ifdef LCD_TIMEOUT_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            PWRUP: begin
                if (tick_q == PWRUP_TERM) begin
                    tick_d  = '0;
                    state_d = INIT_REQ;
                end else begin
                    tick_d = tick_q + CNT_W'(1);
                end
            end
            INIT_REQ: begin
                state_d = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (bus.lcd_finish) begin
                    done_d  = 1'b1;
                    tick_d  = '0;
                    state_d = IDLE;
`ifdef LCD_TIMEOUT_EN
                end else if (tick_q == TO_TERM) begin
                    err_d   = 1'b1;
                    done_d  = 1'b0;
                    tick_d  = '0;
                    state_d = PWRUP;
                end else begin
                    tick_d = tick_q + CNT_W'(1);
`endif
                end
            end
            IDLE: begin
                if (pend_q || tick_q == REFR_TERM) begin
                    tick_d  = '0;
                    pend_d  = bus.upd_req;
                    state_d = REFR_REQ;
                end else begin
                    tick_d = tick_q + CNT_W'(1);
                end
            end
            REFR_REQ: begin
                state_d = REFR_WAIT;
            end
            REFR_WAIT: begin
                if (bus.lcd_finish) begin
                    tick_d  = '0;
                    state_d = IDLE;
`ifdef LCD_TIMEOUT_EN
                end else if (tick_q == TO_TERM) begin
                    err_d   = 1'b1;
                    done_d  = 1'b0;
                    tick_d  = '0;
                    state_d = PWRUP;
                end else begin
                    tick_d = tick_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                tick_d  = '0;
                state_d = PWRUP;
            end
        endcase

        // outputs are registered, so they are decoded from the next state
        if (state_d == INIT_REQ || state_d == PWRUP) begin
            mode_d = 1'b1;
            cnt_d  = INIT_V;
        end else if (state_d == REFR_REQ) begin
            mode_d = 1'b0;
            cnt_d  = REFR_V;
        end
        en_d   = (state_d == INIT_REQ) || (state_d == REFR_REQ);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            state_q <= PWRUP;
            tick_q  <= '0;
            pend_q  <= 1'b0;
            mode_q  <= 1'b1;
            cnt_q   <= INIT_V;
            en_q    <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            pend_q  <= pend_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef LCD_TIMEOUT_EN
    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.lcd_err = err_q;
`else
    assign bus.lcd_err = 1'b0;
`endif

    assign bus.lcd_enable = en_q;
    assign bus.mode       = mode_q;
    assign bus.lcd_cnt    = cnt_q;
    assign bus.lcd_busy   = busy_q;
    assign bus.init_done  = done_q;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Directed bench for lcd_seq_ctrl: expected passes queued on stimulus,
// popped and checked when lcd_enable pulses.
module tb_lcd_seq_ctrl;

    typedef struct {
        logic       mode;
        logic [1:0] cnt;
    } exp_t;

    logic clk_1ms = 1'b0;
    logic reset   = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    exp_t sb[$];

    lcd_seq_ctrl_if bus();

    lcd_seq_ctrl dut (
        .clk_1ms (clk_1ms),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_1ms = ~clk_1ms;

    task automatic step();
        @(posedge clk_1ms);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic m, input logic [1:0] c);
        exp_t e;
        e.mode = m;
        e.cnt  = c;
        sb.push_back(e);
    endtask

    // count edges until lcd_enable is seen, then score mode/lcd_cnt
    task automatic wait_pulse(input string tag, input int exp_edges);
        int   n    = 0;
        logic seen = 1'b0;
        exp_t e;
        e.mode = 1'bx;
        e.cnt  = 2'bxx;
        while (!seen && n < exp_edges + 20) begin
            step();
            n++;
            seen = bus.lcd_enable;
        end
        chk({tag, "_lat"}, n, exp_edges);
        if (sb.size() != 0) e = sb.pop_front();
        chk({tag, "_mode"}, {31'd0, bus.mode}, {31'd0, e.mode});
        chk({tag, "_cnt"}, {30'd0, bus.lcd_cnt}, {30'd0, e.cnt});
        chk({tag, "_busy"}, {31'd0, bus.lcd_busy}, 32'd1);
    endtask

    task automatic finish_pass(input string tag, input int wait_cyc);
        step();
        chk({tag, "_w1"}, {31'd0, bus.lcd_enable}, 32'd0);
        repeat (wait_cyc) step();
        bus.lcd_finish = 1'b1;
        step();
        bus.lcd_finish = 1'b0;
        chk({tag, "_idle"}, {31'd0, bus.lcd_busy}, 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en"}, {31'd0, bus.lcd_enable}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.lcd_busy}, 32'd1);
        chk({tag, "_done"}, {31'd0, bus.init_done}, 32'd0);
        chk({tag, "_mode"}, {31'd0, bus.mode}, 32'd1);
        chk({tag, "_cnt"}, {30'd0, bus.lcd_cnt}, 32'd3);
        chk({tag, "_err"}, {31'd0, bus.lcd_err}, 32'd0);
    endtask

    task automatic quiet(input string tag, input int cyc);
        int n = 0;
        repeat (cyc) begin
            step();
            if (bus.lcd_enable) n++;
        end
        chk(tag, n, 0);
    endtask

    initial begin
        bus.upd_req    = 1'b0;
        bus.lcd_finish = 1'b0;

        // 1: reset values
        repeat (5) step();
        chk_reset_vals("rst");

        // 2: power-up delay and init pass
        reset = 1'b0;
        push(1'b1, 2'd3);
        wait_pulse("init", 20);
        chk("init_done0", {31'd0, bus.init_done}, 32'd0);
        finish_pass("init", 4);
        chk("init_done1", {31'd0, bus.init_done}, 32'd1);

        // finish outside WAIT is ignored
        bus.lcd_finish = 1'b1;
        step();
        bus.lcd_finish = 1'b0;
        chk("stray_fin", {31'd0, bus.lcd_busy}, 32'd0);

        // 3: autonomous refresh, 250 edges after entering IDLE
        push(1'b0, 2'd3);
        wait_pulse("refr1", 249);
        finish_pass("refr1", 3);
        push(1'b0, 2'd3);
        wait_pulse("refr2", 250);
        finish_pass("refr2", 0);
        push(1'b0, 2'd3);
        wait_pulse("refr3", 250);
        finish_pass("refr3", 6);

        // 4: request in IDLE, then merged requests during REFR_WAIT
        bus.upd_req = 1'b1;
        step();
        bus.upd_req = 1'b0;
        push(1'b0, 2'd3);
        wait_pulse("upd", 1);
        step();
        chk("upd_w1", {31'd0, bus.lcd_enable}, 32'd0);
        push(1'b0, 2'd3);
        repeat (3) begin
            bus.upd_req = 1'b1;
            step();
            bus.upd_req = 1'b0;
            step();
        end
        bus.lcd_finish = 1'b1;
        step();
        bus.lcd_finish = 1'b0;
        chk("gap_idle", {31'd0, bus.lcd_busy}, 32'd0);
        wait_pulse("merged", 1);
        finish_pass("merged", 1);
        quiet("no_extra", 30);

        // request held across the launch edge gives one more pass
        bus.upd_req = 1'b1;
        step();
        push(1'b0, 2'd3);
        push(1'b0, 2'd3);
        wait_pulse("sw1", 1);
        bus.upd_req = 1'b0;
        finish_pass("sw1", 2);
        wait_pulse("sw2", 1);
        finish_pass("sw2", 2);
        quiet("sw_quiet", 30);

        // 5: reset two cycles into REFR_WAIT
        bus.upd_req = 1'b1;
        step();
        bus.upd_req = 1'b0;
        push(1'b0, 2'd3);
        wait_pulse("r5", 1);
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("arst");
        step();
        step();
        chk_reset_vals("rst2");
        reset = 1'b0;
        push(1'b1, 2'd3);
        wait_pulse("reinit", 20);
        finish_pass("reinit", 3);
        chk("reinit_done", {31'd0, bus.init_done}, 32'd1);

`ifdef LCD_TIMEOUT_EN
        // 6: init timeout and finish on the timeout cycle
        reset = 1'b1;
        step();
        reset = 1'b0;
        push(1'b1, 2'd3);
        wait_pulse("to_init", 20);
        repeat (50) step();
        chk("to_err0", {31'd0, bus.lcd_err}, 32'd0);
        step();
        chk("to_err1", {31'd0, bus.lcd_err}, 32'd1);
        chk("to_done", {31'd0, bus.init_done}, 32'd0);
        chk("to_busy", {31'd0, bus.lcd_busy}, 32'd1);
        push(1'b1, 2'd3);
        wait_pulse("to_reinit", 20);
        reset = 1'b1;
        step();
        reset = 1'b0;
        push(1'b1, 2'd3);
        wait_pulse("tf_init", 20);
        repeat (50) step();
        bus.lcd_finish = 1'b1;
        step();
        bus.lcd_finish = 1'b0;
        chk("tf_err", {31'd0, bus.lcd_err}, 32'd0);
        chk("tf_done", {31'd0, bus.init_done}, 32'd1);
        chk("tf_idle", {31'd0, bus.lcd_busy}, 32'd0);
`else
        // without timeout, a WAIT state holds indefinitely
        bus.upd_req = 1'b1;
        step();
        bus.upd_req = 1'b0;
        push(1'b0, 2'd3);
        wait_pulse("nto", 1);
        repeat (80) step();
        chk("nto_busy", {31'd0, bus.lcd_busy}, 32'd1);
        chk("nto_err", {31'd0, bus.lcd_err}, 32'd0);
        chk("nto_mode", {31'd0, bus.mode}, 32'd0);
        bus.lcd_finish = 1'b1;
        step();
        bus.lcd_finish = 1'b0;
        chk("nto_idle", {31'd0, bus.lcd_busy}, 32'd0);
`endif

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
